// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Parametrised asynchronous serial receiver with configurable
//                data bits, parity and stop bits. It uses a runtime bit-period
//                divisor. Each received frame is buffered in a show-ahead
//                FIFO with valid/ready output. Every entry carries its own
//                parity and framing error flags. A frame that arrives while
//                the FIFO is full is dropped and sets a sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_BITS   = 8,   // payload bits per frame, 5..9, LSB first
  parameter int PARITY_MODE = 0,   // 0 = none, 1 = even, 2 = odd
  parameter int STOP_BITS   = 1,   // stop bits checked, 1 or 2
  parameter int FIFO_DEPTH  = 16,  // entries, power of two, >= 2
  parameter int DIV_WIDTH   = 16   // width of the bit-period divisor
) (
  input  logic                            cpu_clk,
  input  logic                            cpu_reset_n,
  input  logic                            rx_en,
  input  logic                            rx_in,
  input  logic [DIV_WIDTH-1:0]            div,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_BITS-1:0]            out_data,
  output logic                            out_parity_err,
  output logic                            out_frame_err,
  output logic                            overrun,
  input  logic                            overrun_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int AW  = $clog2(FIFO_DEPTH);       // FIFO pointer width
  localparam int CW  = $clog2(FIFO_DEPTH + 1);   // occupancy width
  localparam int EW  = DATA_BITS + 2;            // {parity_err, frame_err, data}
  localparam int BCW = 4;                        // bit counter, up to 9 data bits

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [BCW-1:0]       DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0]       STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic [CW-1:0]        CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [AW-1:0]        PTR_ONE   = AW'(1);

  // --------------------------------------------------------------------------
  // Line synchroniser
  // --------------------------------------------------------------------------
  logic sync_meta;   // first synchroniser stage, may go metastable
  logic rxs;         // synchronised serial line
  logic prev_rxs;    // rxs delayed one cycle, for falling-edge detection

  // Two-flop synchroniser plus edge history; all idle high out of reset.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      sync_meta <= 1'b1;
      rxs       <= 1'b1;
      prev_rxs  <= 1'b1;
    end else begin
      sync_meta <= rx_in;
      rxs       <= sync_meta;
      prev_rxs  <= rxs;
    end
  end

  // --------------------------------------------------------------------------
  // Receive state machine and datapath
  // --------------------------------------------------------------------------
  logic [2:0]           state;
  logic [DIV_WIDTH-1:0] divl;        // bit period latched for the current frame
  logic [DIV_WIDTH-1:0] baud_cnt;    // cycles since the last sample point
  logic [BCW-1:0]       bit_cnt;     // data or stop bits sampled so far
  logic [DATA_BITS-1:0] shreg;       // payload, filled from the MSB end
  logic                 par_err;     // parity result for the current frame
  logic                 frm_err;     // any stop sample seen low so far
  logic                 push_pending;
  logic [EW-1:0]        push_word;

  logic start_edge;   // idle-to-start condition
  logic sample_tick;  // this cycle is a sample point
  logic parity_bad;   // parity check on the current sample

  // A start is a falling edge of the synchronised line; requiring prev_rxs
  // high means a held-low break cannot retrigger until the line recovers.
  assign start_edge = rx_en & prev_rxs & ~rxs;

  // The start bit is sampled half a period in, every later bit a full period
  // after the previous sample, which keeps every sample mid-bit.
  always_comb begin
    sample_tick = 1'b0;
    if (state == ST_START) begin
      sample_tick = (baud_cnt == ((divl >> 1) - DIV_ONE));
    end else begin
      sample_tick = (baud_cnt == (divl - DIV_ONE));
    end
  end

  // Parity is checked against the full payload plus the sampled parity bit:
  // even parity wants an even total, odd parity an odd one.
  if (PARITY_MODE == 0) begin : g_no_parity
    assign parity_bad = 1'b0;
  end else begin : g_parity
    assign parity_bad = ((^shreg) ^ rxs) != (PARITY_MODE == 2);
  end

  // Frame sequencing: start qualification, bit sampling, and result hand-off.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state        <= ST_IDLE;
      divl         <= DIV_MIN;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_err      <= 1'b0;
      frm_err      <= 1'b0;
      push_pending <= 1'b0;
      push_word    <= '0;
    end else begin
      push_pending <= 1'b0;
      if ((state != ST_IDLE) && !rx_en) begin
        // Disabling mid-frame throws the partial frame away.
        state    <= ST_IDLE;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_edge) begin
              state    <= ST_START;
              baud_cnt <= '0;
              bit_cnt  <= '0;
              par_err  <= 1'b0;
              frm_err  <= 1'b0;
              // Very small divisors cannot place a mid-bit sample; clamp.
              divl     <= (div < DIV_MIN) ? DIV_MIN : div;
            end
          end

          ST_START: begin
            if (sample_tick) begin
              baud_cnt <= '0;
              // A line already back high was a glitch, not a start bit.
              state    <= rxs ? ST_IDLE : ST_DATA;
            end else begin
              baud_cnt <= baud_cnt + DIV_ONE;
            end
          end

          ST_DATA: begin
            if (sample_tick) begin
              baud_cnt <= '0;
              shreg    <= {rxs, shreg[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY_MODE == 0) ? ST_STOP : ST_PARITY;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt + DIV_ONE;
            end
          end

          ST_PARITY: begin
            if (sample_tick) begin
              baud_cnt <= '0;
              par_err  <= parity_bad;
              state    <= ST_STOP;
            end else begin
              baud_cnt <= baud_cnt + DIV_ONE;
            end
          end

          ST_STOP: begin
            if (sample_tick) begin
              baud_cnt <= '0;
              if (!rxs) begin
                frm_err <= 1'b1;
              end
              if (bit_cnt == STOP_LAST) begin
                // Returning to idle right away allows a start bit to follow
                // the last stop sample without losing a cycle.
                bit_cnt      <= '0;
                state        <= ST_IDLE;
                push_pending <= 1'b1;
                push_word    <= {par_err, frm_err | ~rxs, shreg};
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt + DIV_ONE;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead receive FIFO
  // --------------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;

  logic not_empty;
  logic full;
  logic pop;
  logic push_ok;
  logic push_drop;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_FULL);
  assign pop       = not_empty & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_pending & (~full | pop);
  assign push_drop = push_pending & full & ~pop;

  // Storage array; contents need no reset because reads are gated by count.
  always_ff @(posedge cpu_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun; a new drop wins over a same-cycle clear.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      overrun <= 1'b0;
    end else if (push_drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  // Head fields are forced to zero while empty so nothing stale is visible.
  assign head           = mem[rd_ptr];
  assign out_valid      = not_empty;
  assign out_data       = not_empty ? head[DATA_BITS-1:0] : '0;
  assign out_frame_err  = not_empty & head[DATA_BITS];
  assign out_parity_err = not_empty & head[DATA_BITS+1];
  assign fifo_count     = count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo (8 data bits, even
//                parity, 1 stop bit, 4-entry FIFO). Frames are pushed to an
//                expected-entry queue as they are driven and compared as the
//                consumer side pops them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DBITS = 8;
  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic          cpu_clk = 1'b0;
  logic          cpu_reset_n;
  logic          rx_en;
  logic          rx_in;
  logic [DW-1:0] div;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_parity_err;
  logic          out_frame_err;
  logic          overrun;
  logic          overrun_clr;
  logic [2:0]    fifo_count;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  logic [9:0] sb [$];   // expected {parity_err, frame_err, data}
  logic [9:0] exp_e;

  uart_rx_fifo #(
    .DATA_BITS   (DBITS),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (DEPTH),
    .DIV_WIDTH   (DW)
  ) dut (
    .cpu_clk        (cpu_clk),
    .cpu_reset_n    (cpu_reset_n),
    .rx_en          (rx_en),
    .rx_in          (rx_in),
    .div            (div),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_parity_err (out_parity_err),
    .out_frame_err  (out_frame_err),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr),
    .fifo_count     (fifo_count)
  );

  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Consumer side: every pop is compared against the oldest expected entry.
  always @(negedge cpu_clk) begin
    if (cpu_reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_entry", {22'd0, out_parity_err, out_frame_err, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_e = sb.pop_front();
        check("entry", {22'd0, out_parity_err, out_frame_err, out_data}, {22'd0, exp_e});
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Drives one frame: start, 8 data bits LSB first, parity bit, stop bit.
  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop, input int d);
    rx_in = 1'b0;
    repeat (d) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      repeat (d) tick();
    end
    rx_in = pbit;
    repeat (d) tick();
    rx_in = stop;
    repeat (d) tick();
  endtask

  task automatic send_good(input logic [7:0] data, input int d);
    sb.push_back({2'b00, data});
    send_frame(data, ^data, 1'b1, d);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 2000 && (sb.size() != 0 || out_valid); i++) tick();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    bit  seen;

    cpu_reset_n = 1'b0;
    rx_en       = 1'b1;
    rx_in       = 1'b1;
    out_ready   = 1'b1;
    overrun_clr = 1'b0;
    div         = 16'd8;
    repeat (3) tick();
    check("rst_valid",  32'(out_valid),      32'd0);
    check("rst_count",  32'(fifo_count),     32'd0);
    check("rst_overrun", 32'(overrun),       32'd0);
    check("rst_data",   32'(out_data),       32'd0);
    check("rst_perr",   32'(out_parity_err), 32'd0);
    check("rst_ferr",   32'(out_frame_err),  32'd0);
    cpu_reset_n = 1'b1;
    repeat (5) tick();
    check("empty_ready_count", 32'(fifo_count), 32'd0);

    // Back-to-back frames; first out_valid lands 4 + d/2 + 10*d cycles after
    // the start bit is driven.
    c0   = cyc;
    seen = 1'b0;
    fork
      begin
        send_good(8'hA5, 8);
        send_good(8'h3C, 8);
      end
      begin
        for (int i = 0; i < 300; i++) begin
          @(negedge cpu_clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("valid_latency", seen ? 32'(cyc - c0) : 32'hFFFF_FFFF, 32'd88);
      end
    join
    drain("drain_b2b");
    check("count_b2b", 32'(fifo_count), 32'd0);

    // Parity: 0x03 has even weight, so parity bit 1 is an error.
    sb.push_back({2'b10, 8'h03});
    send_frame(8'h03, 1'b1, 1'b1, 8);
    sb.push_back({2'b00, 8'h03});
    send_frame(8'h03, 1'b0, 1'b1, 8);
    drain("drain_parity");

    // Framing error followed by a held-low break.
    sb.push_back({2'b01, 8'h81});
    send_frame(8'h81, ^8'h81, 1'b0, 8);
    repeat (40) tick();
    check("break_count", 32'(fifo_count), 32'd0);
    check("break_sb",    32'(sb.size()),  32'd0);
    rx_in = 1'b1;
    repeat (20) tick();
    check("break_idle_count", 32'(fifo_count), 32'd0);
    send_good(8'h42, 8);
    drain("drain_break");

    // Overrun: five frames into a four-entry FIFO with no consumer.
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) sb.push_back({2'b00, 8'(v)});
      send_frame(8'(v), ^(8'(v)), 1'b1, 8);
    end
    repeat (4) tick();
    check("ovr_count", 32'(fifo_count), 32'd4);
    check("ovr_flag",  32'(overrun),    32'd1);
    check("ovr_head",  32'(out_data),   32'h01);
    drain("drain_ovr");
    check("ovr_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    tick();
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Full FIFO with a pop on the exact push cycle of the fifth frame.
    out_ready = 1'b0;
    for (int v = 8'h11; v <= 8'h14; v++) send_good(8'(v), 8);
    repeat (4) tick();
    check("full_count_before", 32'(fifo_count), 32'd4);
    sb.push_back({2'b00, 8'h15});
    fork
      send_frame(8'h15, ^8'h15, 1'b1, 8);
      begin
        repeat (3 + 4 + 80) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    join
    check("full_pop_count",   32'(fifo_count), 32'd4);
    check("full_pop_overrun", 32'(overrun),    32'd0);
    drain("drain_full");

    // Glitch, then abort during data bit 3, then a clean frame (div = 16).
    div   = 16'd16;
    rx_in = 1'b0;
    repeat (3) tick();
    rx_in = 1'b1;
    repeat (40) tick();
    check("glitch_count", 32'(fifo_count), 32'd0);
    fork
      send_frame(8'h77, ^8'h77, 1'b1, 16);
      begin
        repeat (16 + 3 * 16 + 8) tick();
        rx_en = 1'b0;
      end
    join
    repeat (10) tick();
    rx_en = 1'b1;
    repeat (20) tick();
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_sb",    32'(sb.size()),  32'd0);
    send_good(8'h5A, 16);
    drain("drain_after_abort");
    check("final_count", 32'(fifo_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with an integrated show-ahead receive FIFO; next generation of the fixed 8N1 UART receive monitor in the CPU test top.
- Adds configurable data bits, parity, stop bits, runtime divisor, per-byte error flags, sticky overrun and FIFO buffering with a valid/ready output.
- Sits on the cpu_clk domain, sampling the CPU subsystem uart_tx line; feeds the testbench console printer or an AXI-Lite status/data register block.

Parameters:
- DATA_BITS, 8, payload bits per frame (5..9), LSB first.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits checked (1 or 2).
- FIFO_DEPTH, 16, receive FIFO entries (power of two, >= 2).
- DIV_WIDTH, 16, width of the bit-period divisor input.

Ports:
- cpu_clk  in  1  clock
- cpu_reset_n  in  1  asynchronous, active-low reset
- rx_en  in  1  receiver enable
- rx_in  in  1  serial line, asynchronous, idle high
- div  in  DIV_WIDTH  bit period in cpu_clk cycles (868 = 100 MHz / 115200)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer pops head when out_valid & out_ready
- out_data  out  DATA_BITS  head entry payload
- out_parity_err  out  1  head entry parity error flag
- out_frame_err  out  1  head entry framing error flag
- overrun  out  1  sticky, a frame was dropped because the FIFO was full
- overrun_clr  in  1  clears overrun
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM IDLE; synchroniser flops and previous-sample flop = 1.
- rx_in passes through a 2-flop synchroniser, giving rxs. Detection latency is 2 cycles.
- Divisor is latched at start detection. Latched value is max(div, 4). A div change mid-frame applies from the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START: rx_en & prev_rxs == 1 & rxs == 0. The bit counter is cleared.
  - START: wait (divl >> 1) cycles, then sample. If the sample is 1 (glitch), go to IDLE with no push. Otherwise go to DATA.
  - DATA: sample every divl cycles and shift in LSB first. After DATA_BITS samples, go to PARITY, or to STOP when PARITY_MODE == 0.
  - PARITY: one sample. parity_err = XOR(data, bit) != (PARITY_MODE == 2).
  - STOP: STOP_BITS samples, divl apart. frame_err = 1 if any stop sample is 0. After the last sample, push and go to IDLE in the same cycle, so back-to-back frames are supported.
  - rx_en low in any non-IDLE state: go to IDLE on the next cycle. The partial frame is discarded and nothing is pushed.
- Break handling: after a frame error with the line held low, no new start is detected until rxs returns to 1 (prev_rxs == 1 edge rule).
- Push: {parity_err, frame_err, data} is written on the cycle after the last stop sample. out_valid rises the following cycle.
- FIFO:
  - Show-ahead: the out_* head fields are valid whenever out_valid = 1.
  - Pop: on out_valid & out_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full:
  - Push with count == FIFO_DEPTH and no same-cycle pop: entry dropped, overrun set to 1, existing contents unchanged.
  - Push with count == FIFO_DEPTH and a same-cycle pop: accepted, no overrun.
- Empty: out_ready is ignored; count stays 0.
- overrun: set has priority over overrun_clr in the same cycle.
- Reset asserted mid-frame or with a non-empty FIFO: immediate return to reset values, with no partial push.

Test Plan:
- 8N1, div=8: send 0xA5 then 0x3C back-to-back, out_ready=1. Expect out_data 0xA5 then 0x3C, both error flags 0, fifo_count returning to 0, out_valid rising 1 cycle after each push.
- PARITY_MODE=1, div=8: send 0x03 with parity bit 1. Expect out_data 0x03, out_parity_err=1. Send 0x03 with parity bit 0; expect out_parity_err=0.
- Stop bit driven 0 for 0x81, then line held low for 40 cycles. Expect one entry 0x81 with out_frame_err=1, and no further entries until the line returns high and a new start occurs.
- FIFO_DEPTH=4, out_ready=0: send 0x01..0x05. Expect fifo_count=4, overrun=1, pops yield 0x01..0x04. Then pulse overrun_clr; expect overrun=0.
- Full FIFO: hold out_ready=1 on the exact push cycle of a 5th byte. Expect overrun stays 0 and fifo_count stays 4.
- Glitch and abort, div=16: a 3-cycle low pulse gives no entry. Drop rx_en during DATA bit 3; expect no entry. A subsequent full frame 0x5A is received correctly.
